boot_copy_sequencer: RTL and testbench

Boot-time controller for the chipset memory path. After reset it owns the ROM and RAM buses, copies `COPY_LEN` bytes from ROM address 0 into RAM starting at `DST_BASE`, then hands the RAM bus to the CPU. It holds the CPU stalled until the copy completes. It sits between the CPU bus and the RAM/ROM macros, replacing any direct CPU-to-RAM wiring.

---
 rtl/boot_copy_sequencer_if.sv | 67 ++++++
 rtl/boot_copy_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_boot_copy_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_copy_sequencer_if.sv
// Bus bundle between boot_copy_sequencer and the ROM/RAM/CPU side of the memory path.
// Latency: none; pure wiring bundle.
// Backpressure: none on the buses; the CPU is stalled with cpu_hold.

package boot_copy_pkg;
    typedef logic [7:0] default_t;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_flag_t;
endpackage

interface boot_copy_sequencer_if;
    // ROM port
    boot_copy_pkg::default_t  rom_read_bus;
    boot_copy_pkg::default_t  rom_addr_bus;
    // RAM port
    boot_copy_pkg::default_t  mem_read_bus;
    boot_copy_pkg::mem_flag_t mem_ctrl_bus;
    boot_copy_pkg::default_t  mem_addr_bus;
    boot_copy_pkg::default_t  mem_write_bus;
    // CPU port
    boot_copy_pkg::mem_flag_t cpu_ctrl_bus;
    boot_copy_pkg::default_t  cpu_addr_bus;
    boot_copy_pkg::default_t  cpu_write_bus;
    boot_copy_pkg::default_t  cpu_read_bus;
    logic                     cpu_hold;
    // Status
    logic                     boot_done;
    logic                     boot_error;

    // Sequencer side
    modport master (
        input  rom_read_bus,
        output rom_addr_bus,
        input  mem_read_bus,
        output mem_ctrl_bus,
        output mem_addr_bus,
        output mem_write_bus,
        input  cpu_ctrl_bus,
        input  cpu_addr_bus,
        input  cpu_write_bus,
        output cpu_read_bus,
        output cpu_hold,
        output boot_done,
        output boot_error
    );

    // Memory macros / CPU side
    modport slave (
        output rom_read_bus,
        input  rom_addr_bus,
        output mem_read_bus,
        input  mem_ctrl_bus,
        input  mem_addr_bus,
        input  mem_write_bus,
        output cpu_ctrl_bus,
        output cpu_addr_bus,
        output cpu_write_bus,
        input  cpu_read_bus,
        input  cpu_hold,
        input  boot_done,
        input  boot_error
    );
endinterface

// File: rtl/boot_copy_sequencer.sv
// Boot copier: after RESET copies COPY_LEN ROM bytes to RAM at DST_BASE, then gives RAM to the CPU.
// Latency: 1 + COPY_LEN cycles to S_RUN, plus 1 + COPY_LEN more when BOOT_VERIFY_EN is defined.
// Backpressure: none; CPU held by cpu_hold until boot_done. Macros: BOOT_VERIFY_EN (read-back check), ROMSIZE (default length).

`ifndef ROMSIZE
`define ROMSIZE 256
`endif

module boot_copy_sequencer
    import boot_copy_pkg::*;
#(
    parameter int unsigned COPY_LEN = `ROMSIZE,
    parameter logic [7:0]  DST_BASE = 8'h00
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    boot_copy_sequencer_if.master bus
);

`ifdef BOOT_VERIFY_EN
    typedef enum logic [2:0] {
        S_FILL   = 3'd0,
        S_COPY   = 3'd1,
        S_VFILL  = 3'd2,
        S_VERIFY = 3'd3,
        S_RUN    = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_COPY = 2'd1,
        S_RUN  = 2'd2
    } state_t;
`endif

    // Index of the final byte; idx is 9 bits so COPY_LEN = 256 still fits.
    localparam logic [8:0] LAST_IDX = 9'(COPY_LEN - 1);

    state_t     state_q, state_d;
    logic [8:0] idx_q, idx_d;
    logic       boot_done_q, boot_done_d;

    logic [7:0] idx_lo;
    logic [7:0] idx_inc;
    logic       last_byte;

    assign idx_lo    = idx_q[7:0];
    assign idx_inc   = idx_lo + 8'd1;
    assign last_byte = (idx_q == LAST_IDX);

`ifdef BOOT_VERIFY_EN
    logic boot_error_q, boot_error_d;
`endif

    // Next-state, byte counter and status flag computation.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        boot_done_d = boot_done_q;
`ifdef BOOT_VERIFY_EN
        boot_error_d = boot_error_q;
`endif
        case (state_q)
            S_FILL: begin
                // ROM address 0 is presented this cycle, so byte 0 is ready for the first copy cycle.
                state_d = S_COPY;
                idx_d   = 9'd0;
            end
            S_COPY: begin
                if (last_byte) begin
                    idx_d = 9'd0;
`ifdef BOOT_VERIFY_EN
                    state_d = S_VFILL;
`else
                    state_d     = S_RUN;
                    boot_done_d = 1'b1;
`endif
                end else begin
                    idx_d = idx_q + 9'd1;
                end
            end
`ifdef BOOT_VERIFY_EN
            S_VFILL: begin
                state_d = S_VERIFY;
                idx_d   = 9'd0;
            end
            S_VERIFY: begin
                // Mismatch is sticky; the CPU is released regardless.
                if (bus.rom_read_bus != bus.mem_read_bus) begin
                    boot_error_d = 1'b1;
                end
                if (last_byte) begin
                    state_d     = S_RUN;
                    boot_done_d = 1'b1;
                    idx_d       = 9'd0;
                end else begin
                    idx_d = idx_q + 9'd1;
                end
            end
`endif
            S_RUN: begin
                // Terminal until RESET.
                state_d = S_RUN;
            end
            default: begin
                state_d     = S_FILL;
                idx_d       = 9'd0;
                boot_done_d = 1'b0;
            end
        endcase
    end

    // FSM, counter and registered status outputs; synchronous reset restarts the copy.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= S_FILL;
            idx_q       <= 9'd0;
            boot_done_q <= 1'b0;
`ifdef BOOT_VERIFY_EN
            boot_error_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            boot_done_q <= boot_done_d;
`ifdef BOOT_VERIFY_EN
            boot_error_q <= boot_error_d;
`endif
        end
    end

    // Bus steering: sequencer owns ROM/RAM until S_RUN, then RAM follows the CPU combinationally.
    always_comb begin
        bus.rom_addr_bus  = 8'h00;
        bus.mem_ctrl_bus  = MEM_NOP;
        bus.mem_addr_bus  = 8'h00;
        bus.mem_write_bus = 8'h00;
        bus.cpu_read_bus  = 8'h00;
        case (state_q)
            S_COPY: begin
                // ROM data for idx arrived this cycle; prefetch idx + 1 (wraps harmlessly on the last byte).
                bus.rom_addr_bus  = idx_inc;
                bus.mem_ctrl_bus  = MEM_WRITE;
                bus.mem_addr_bus  = DST_BASE + idx_lo;
                bus.mem_write_bus = bus.rom_read_bus;
            end
`ifdef BOOT_VERIFY_EN
            S_VFILL: begin
                bus.rom_addr_bus = 8'h00;
                bus.mem_ctrl_bus = MEM_READ;
                bus.mem_addr_bus = DST_BASE;
            end
            S_VERIFY: begin
                bus.rom_addr_bus = idx_inc;
                bus.mem_ctrl_bus = MEM_READ;
                bus.mem_addr_bus = DST_BASE + idx_inc;
            end
`endif
            S_RUN: begin
                bus.mem_ctrl_bus  = bus.cpu_ctrl_bus;
                bus.mem_addr_bus  = bus.cpu_addr_bus;
                bus.mem_write_bus = bus.cpu_write_bus;
                bus.cpu_read_bus  = bus.mem_read_bus;
            end
            default: begin
                bus.mem_ctrl_bus = MEM_NOP;
            end
        endcase
        // A reset cycle must never commit a RAM access, whatever step was in flight.
        if (RESET) begin
            bus.mem_ctrl_bus = MEM_NOP;
        end
    end

    assign bus.boot_done = boot_done_q;
    assign bus.cpu_hold  = ~boot_done_q;
`ifdef BOOT_VERIFY_EN
    assign bus.boot_error = boot_error_q;
`else
    assign bus.boot_error = 1'b0;
`endif

endmodule

// File: tb/tb_boot_copy_sequencer.sv
// Bench for boot_copy_sequencer: two instances (4 bytes at 0x10, 256 bytes at 0xF0) with ROM/RAM models.
// Latency expectations follow BOOT_VERIFY_EN.
// Backpressure: none; CPU traffic is driven freely and must be ignored until boot_done.

module tb_boot_copy_sequencer;
    import boot_copy_pkg::*;

`ifdef BOOT_VERIFY_EN
    localparam int LAT_A = 10;
    localparam int LAT_B = 514;
    localparam bit VERIFY = 1'b1;
`else
    localparam int LAT_A = 5;
    localparam int LAT_B = 257;
    localparam bit VERIFY = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    boot_copy_sequencer_if if_a ();
    boot_copy_sequencer_if if_b ();

    boot_copy_sequencer #(.COPY_LEN(4), .DST_BASE(8'h10)) dut_a (
        .CLOCK (clk),
        .RESET (rst_a),
        .bus   (if_a)
    );

    boot_copy_sequencer #(.COPY_LEN(256), .DST_BASE(8'hF0)) dut_b (
        .CLOCK (clk),
        .RESET (rst_b),
        .bus   (if_b)
    );

    // ---------------- memory models ----------------
    logic [7:0] rom_a [256];
    logic [7:0] ram_a [256];
    logic [7:0] rom_b [256];
    logic [7:0] ram_b [256];
    int         wcnt_b [256];
    bit         fault_en = 1'b0;

    always @(posedge clk) begin
        if_a.rom_read_bus <= rom_a[if_a.rom_addr_bus];
        if (if_a.mem_ctrl_bus == MEM_WRITE)
            ram_a[if_a.mem_addr_bus] <= (fault_en && if_a.mem_addr_bus == 8'h12) ?
                                        (if_a.mem_write_bus ^ 8'hFF) : if_a.mem_write_bus;
        if (if_a.mem_ctrl_bus == MEM_READ)
            if_a.mem_read_bus <= ram_a[if_a.mem_addr_bus];
    end

    always @(posedge clk) begin
        if_b.rom_read_bus <= rom_b[if_b.rom_addr_bus];
        if (if_b.mem_ctrl_bus == MEM_WRITE)
            ram_b[if_b.mem_addr_bus] <= if_b.mem_write_bus;
        if (if_b.mem_ctrl_bus == MEM_READ)
            if_b.mem_read_bus <= ram_b[if_b.mem_addr_bus];
        if (rst_b) begin
            for (int i = 0; i < 256; i++) wcnt_b[i] <= 0;
        end else if (if_b.mem_ctrl_bus == MEM_WRITE) begin
            wcnt_b[if_b.mem_addr_bus] <= wcnt_b[if_b.mem_addr_bus] + 1;
        end
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        mem_flag_t  cctl;
        logic [7:0] cadr;
        logic [7:0] cwd;
        logic       chk_en;
        logic [7:0] e_rom;
        mem_flag_t  e_ctl;
        logic [7:0] e_adr;
        logic [7:0] e_wd;
        logic       e_hold;
        logic       e_done;
    } vec_t;

    // CPU keeps trying to write 0x77 to 0x11 throughout; it must never reach RAM during boot.
    function automatic vec_t mk(logic r, logic c, logic [7:0] er, mem_flag_t ec,
                                logic [7:0] ea, logic [7:0] ew);
        vec_t v;
        v.rst = r;  v.cctl = MEM_WRITE; v.cadr = 8'h11; v.cwd = 8'h77;
        v.chk_en = c; v.e_rom = er; v.e_ctl = ec; v.e_adr = ea; v.e_wd = ew;
        v.e_hold = 1'b1; v.e_done = 1'b0;
        return v;
    endfunction

    // One-cycle reset pulse on instance A, then count cycles from the S_FILL cycle until boot_done.
    task automatic boot_a(output int lat);
        @(negedge clk);
        rst_a = 1'b1;
        if_a.cpu_ctrl_bus = MEM_NOP;
        @(negedge clk);
        rst_a = 1'b0;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (if_a.boot_done === 1'b1) begin
                lat = k;
                break;
            end
            chk("a_hold_during_boot", int'(if_a.cpu_hold), 1);
            chk("a_cpu_rd_during_boot", int'(if_a.cpu_read_bus), 0);
            @(negedge clk);
        end
    endtask

    task automatic drive_rand_b;
        int op;
        op = $urandom_range(0, 2);
        if_b.cpu_ctrl_bus  = (op == 0) ? MEM_NOP : ((op == 1) ? MEM_READ : MEM_WRITE);
        if_b.cpu_addr_bus  = 8'($urandom);
        if_b.cpu_write_bus = 8'($urandom);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl [11];
        logic [7:0] romv [4];
        logic [7:0] exp_b [256];
        int         lat;
        int         r;
        bit         pend;
        logic [7:0] pend_val;

        romv[0] = 8'h11; romv[1] = 8'h22; romv[2] = 8'h33; romv[3] = 8'h44;
        for (int i = 0; i < 256; i++) begin
            rom_a[i] = (i < 4) ? romv[i] : 8'hEE;
            rom_b[i] = 8'($urandom);
        end
        if_a.cpu_ctrl_bus = MEM_NOP; if_a.cpu_addr_bus = 8'h00; if_a.cpu_write_bus = 8'h00;
        if_b.cpu_ctrl_bus = MEM_NOP; if_b.cpu_addr_bus = 8'h00; if_b.cpu_write_bus = 8'h00;

        // ---- table: reset values, copy sequence, reset on third copy cycle, restart ----
        tbl[0]  = mk(1'b1, 1'b0, 8'h00, MEM_NOP,   8'h00, 8'h00);
        tbl[1]  = mk(1'b1, 1'b1, 8'h00, MEM_NOP,   8'h00, 8'h00);
        tbl[2]  = mk(1'b0, 1'b1, 8'h00, MEM_NOP,   8'h00, 8'h00);
        tbl[3]  = mk(1'b0, 1'b1, 8'h01, MEM_WRITE, 8'h10, 8'h11);
        tbl[4]  = mk(1'b0, 1'b1, 8'h02, MEM_WRITE, 8'h11, 8'h22);
        tbl[5]  = mk(1'b1, 1'b1, 8'h03, MEM_NOP,   8'h12, 8'h33);
        tbl[6]  = mk(1'b0, 1'b1, 8'h00, MEM_NOP,   8'h00, 8'h00);
        tbl[7]  = mk(1'b0, 1'b1, 8'h01, MEM_WRITE, 8'h10, 8'h11);
        tbl[8]  = mk(1'b0, 1'b1, 8'h02, MEM_WRITE, 8'h11, 8'h22);
        tbl[9]  = mk(1'b0, 1'b1, 8'h03, MEM_WRITE, 8'h12, 8'h33);
        tbl[10] = mk(1'b0, 1'b1, 8'h04, MEM_WRITE, 8'h13, 8'h44);

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            rst_a              = tbl[i].rst;
            if_a.cpu_ctrl_bus  = tbl[i].cctl;
            if_a.cpu_addr_bus  = tbl[i].cadr;
            if_a.cpu_write_bus = tbl[i].cwd;
            #1;
            if (tbl[i].chk_en) begin
                chk($sformatf("tbl%0d_rom_addr", i), int'(if_a.rom_addr_bus), int'(tbl[i].e_rom));
                chk($sformatf("tbl%0d_mem_ctrl", i), int'(if_a.mem_ctrl_bus), int'(tbl[i].e_ctl));
                chk($sformatf("tbl%0d_mem_addr", i), int'(if_a.mem_addr_bus), int'(tbl[i].e_adr));
                chk($sformatf("tbl%0d_mem_wdat", i), int'(if_a.mem_write_bus), int'(tbl[i].e_wd));
                chk($sformatf("tbl%0d_cpu_rd", i), int'(if_a.cpu_read_bus), 0);
                chk($sformatf("tbl%0d_hold", i), int'(if_a.cpu_hold), int'(tbl[i].e_hold));
                chk($sformatf("tbl%0d_done", i), int'(if_a.boot_done), int'(tbl[i].e_done));
                chk($sformatf("tbl%0d_error", i), int'(if_a.boot_error), 0);
            end
        end

        // Row 6 was the S_FILL cycle after the mid-copy reset; count from there.
        lat = -1;
        for (int k = 5; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (if_a.boot_done === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk("a_restart_latency", lat, LAT_A);
        chk("a_hold_after_done", int'(if_a.cpu_hold), 0);
        chk("a_error_no_fault", int'(if_a.boot_error), 0);
        for (int j = 0; j < 4; j++)
            chk($sformatf("a_ram_%0h", 16 + j), int'(ram_a[8'(16 + j)]), int'(romv[j]));

        // ---- CPU access after boot ----
        if_a.cpu_ctrl_bus = MEM_WRITE; if_a.cpu_addr_bus = 8'h20; if_a.cpu_write_bus = 8'hA5;
        #1;
        chk("a_run_ctrl_pass", int'(if_a.mem_ctrl_bus), int'(MEM_WRITE));
        chk("a_run_addr_pass", int'(if_a.mem_addr_bus), 8'h20);
        chk("a_run_wdat_pass", int'(if_a.mem_write_bus), 8'hA5);
        chk("a_run_rom_addr", int'(if_a.rom_addr_bus), 0);
        @(negedge clk);
        if_a.cpu_ctrl_bus = MEM_READ; if_a.cpu_addr_bus = 8'h20;
        @(negedge clk);
        #1;
        chk("a_cpu_read_20", int'(if_a.cpu_read_bus), 8'hA5);
        if_a.cpu_ctrl_bus = MEM_WRITE; if_a.cpu_addr_bus = 8'h11; if_a.cpu_write_bus = 8'h99;
        @(negedge clk);
        if_a.cpu_ctrl_bus = MEM_NOP;
        #1;
        chk("a_cpu_wrote_11", int'(ram_a[8'h11]), 8'h99);

        // ---- reset during S_RUN re-copies over CPU data ----
        boot_a(lat);
        chk("a_reboot_latency", lat, LAT_A);
        chk("a_reboot_ram_11", int'(ram_a[8'h11]), 8'h22);
        chk("a_reboot_ram_20", int'(ram_a[8'h20]), 8'hA5);

        // ---- corrupted RAM write at 0x12 ----
        fault_en = 1'b1;
        boot_a(lat);
        fault_en = 1'b0;
        chk("a_fault_latency", lat, LAT_A);
        chk("a_fault_error", int'(if_a.boot_error), int'(VERIFY));
        chk("a_fault_done", int'(if_a.boot_done), 1);
        boot_a(lat);
        chk("a_clean_error_cleared", int'(if_a.boot_error), 0);
        chk("a_clean_ram_12", int'(ram_a[8'h12]), 8'h33);

        // ---- instance B: 256 random bytes at 0xF0, random CPU noise, random mid-boot reset ----
        @(negedge clk); rst_b = 1'b1;
        @(negedge clk); rst_b = 1'b0;
        r = $urandom_range(2, 200);
        repeat (r) begin
            @(negedge clk);
            drive_rand_b();
        end
        @(negedge clk);
        rst_b = 1'b1;
        drive_rand_b();
        #1;
        chk("b_reset_cycle_nop", int'(if_b.mem_ctrl_bus), int'(MEM_NOP));
        @(negedge clk);
        rst_b = 1'b0;
        lat = -1;
        for (int k = 0; k < 700; k++) begin
            drive_rand_b();
            #1;
            if (if_b.boot_done === 1'b1) begin
                if_b.cpu_ctrl_bus = MEM_NOP;
                lat = k;
                break;
            end
            if (if_b.cpu_read_bus !== 8'h00 || if_b.cpu_hold !== 1'b1)
                chk("b_cpu_isolated", {int'(if_b.cpu_hold), int'(if_b.cpu_read_bus)}, 1);
            @(negedge clk);
        end
        chk("b_latency", lat, LAT_B);
        for (int a = 0; a < 256; a++) begin
            exp_b[a] = rom_b[8'(a - 8'hF0)];
            chk($sformatf("b_ram_%02h", a), int'(ram_b[a]), int'(exp_b[a]));
            chk($sformatf("b_wcnt_%02h", a), wcnt_b[a], 1);
        end

        // ---- random CPU traffic against a flat memory model ----
        pend = 1'b0;
        pend_val = 8'h00;
        for (int c = 0; c < 300; c++) begin
            int         op;
            logic [7:0] ad, dt;
            @(negedge clk);
            if (pend) chk("b_cpu_read", int'(if_b.cpu_read_bus), int'(pend_val));
            op = $urandom_range(0, 2);
            ad = 8'($urandom);
            dt = 8'($urandom);
            if_b.cpu_addr_bus  = ad;
            if_b.cpu_write_bus = dt;
            pend = 1'b0;
            if (op == 1) begin
                if_b.cpu_ctrl_bus = MEM_READ;
                pend = 1'b1;
                pend_val = exp_b[ad];
            end else if (op == 2) begin
                if_b.cpu_ctrl_bus = MEM_WRITE;
                exp_b[ad] = dt;
            end else begin
                if_b.cpu_ctrl_bus = MEM_NOP;
            end
        end
        @(negedge clk);
        if (pend) chk("b_cpu_read_last", int'(if_b.cpu_read_bus), int'(pend_val));
        if_b.cpu_ctrl_bus = MEM_NOP;
        chk("b_done_held", int'(if_b.boot_done), 1);
        chk("b_error_no_fault", int'(if_b.boot_error), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
